// File: rtl/padd_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
//   PADD_WIDTH / PADD_CHUNK : default operand width and bits per stage
//   padd_mode_e             : sub input encoding (MODE_ADD / MODE_SUB)
//   padd_stages()           : pipeline depth for a given width/chunk pair
package padd_pkg;

  localparam int PADD_WIDTH = 16;
  localparam int PADD_CHUNK = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } padd_mode_e;

  function automatic int padd_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/padd_chunk.sv
// Combinational CHUNK-bit ripple adder used as one pipeline stage.
//   a, b     : chunk operands (b already inverted for subtraction)
//   ci       : carry into bit 0 of the chunk
//   s        : chunk sum
//   co       : carry out of the chunk MSB
//   c_msb_in : carry into the chunk MSB (needed for signed overflow)
module padd_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/padd_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, CHUNK bits summed per stage.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   out_valid / out_ready: result handshake (s, cout, ovf)
//   sub=0 : s = a + b + cin ; sub=1 : s = a - b (cin ignored)
//   cout  : carry out of the MSB (1 = no borrow in sub mode)
//   ovf   : signed overflow, carry into MSB xor carry out of MSB
//
// Handshake: a beat transfers on a rising edge where valid && ready.
// The whole pipeline advances together when the output slot is empty or
// being drained (adv); otherwise every stage, bubbles included, holds.
// in_ready is exactly adv, so it is combinational from out_ready.
module padd_pipe
  import padd_pkg::*;
#(
  parameter int WIDTH = PADD_WIDTH,
  parameter int CHUNK = PADD_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = padd_stages(WIDTH, CHUNK);

  // Stage k registers. a_q/b_q are the skew registers carrying the operand
  // chunks still to be consumed; s_q collects the chunks produced so far.
  logic             v_q   [STAGES];
  logic             c_q   [STAGES];
  logic             ovf_q [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1: invert b once at the entry, force carry-in.
  assign b_eff   = (sub == MODE_SUB) ? ~b : b;
  assign cin_eff = (sub == MODE_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [CHUNK-1:0] s_chunk;
    logic             co;
    logic             c_msb;
    logic [WIDTH-1:0] s_nx;

    if (k == 0) begin : g_first
      assign a_in = a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = cin_eff;
      assign v_in = in_valid;
    end else begin : g_next
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = s_q[k-1];
      assign c_in = c_q[k-1];
      assign v_in = v_q[k-1];
    end

    padd_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_in[k*CHUNK +: CHUNK]),
      .b        (b_in[k*CHUNK +: CHUNK]),
      .ci       (c_in),
      .s        (s_chunk),
      .co       (co),
      .c_msb_in (c_msb)
    );

    always_comb begin
      s_nx                      = s_in;
      s_nx[k*CHUNK +: CHUNK]    = s_chunk;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q[k]   <= 1'b0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end else if (adv) begin
        v_q[k]   <= v_in;
        c_q[k]   <= co;
        // Only meaningful in the last stage, where c_msb is carry into bit WIDTH-1.
        ovf_q[k] <= co ^ c_msb;
        a_q[k]   <= a_in;
        b_q[k]   <= b_in;
        s_q[k]   <= s_nx;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_padd_pipe.sv
// Directed bench for padd_pipe (16/4 main instance, 4/4 single-stage instance).
module tb_padd_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  logic        s1_in_valid;
  logic        s1_in_ready;
  logic [3:0]  s1_a;
  logic [3:0]  s1_b;
  logic        s1_cin;
  logic        s1_sub;
  logic        s1_out_valid;
  logic        s1_out_ready;
  logic [3:0]  s1_s;
  logic        s1_cout;
  logic        s1_ovf;

  int total;
  int bad;

  logic [15:0] exp_q[$];

  padd_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  padd_pipe #(.WIDTH(4), .CHUNK(4)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .a         (s1_a),
    .b         (s1_b),
    .cin       (s1_cin),
    .sub       (s1_sub),
    .out_valid (s1_out_valid),
    .out_ready (s1_out_ready),
    .s         (s1_s),
    .cout      (s1_cout),
    .ovf       (s1_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL reset_s: got %h want 0000", s); end
    total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // Single beats through an idle pipeline, checking latency and arithmetic.
  task automatic test_arith();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic        vm [6];
    logic [15:0] es [6];
    logic        ec [6];
    logic        eo [6];
    va[0] = 16'h1234; vb[0] = 16'h0FFF; vc[0] = 1; vm[0] = 0; es[0] = 16'h2234; ec[0] = 0; eo[0] = 0;
    va[1] = 16'hFFFF; vb[1] = 16'h0000; vc[1] = 1; vm[1] = 0; es[1] = 16'h0000; ec[1] = 1; eo[1] = 0;
    va[2] = 16'h8000; vb[2] = 16'h0001; vc[2] = 1; vm[2] = 1; es[2] = 16'h7FFF; ec[2] = 1; eo[2] = 1;
    va[3] = 16'h0003; vb[3] = 16'h0005; vc[3] = 0; vm[3] = 1; es[3] = 16'hFFFE; ec[3] = 0; eo[3] = 0;
    va[4] = 16'h7FFF; vb[4] = 16'h0001; vc[4] = 0; vm[4] = 0; es[4] = 16'h8000; ec[4] = 0; eo[4] = 1;
    va[5] = 16'h1000; vb[5] = 16'h1000; vc[5] = 0; vm[5] = 1; es[5] = 16'h0000; ec[5] = 1; eo[5] = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; sub = vm[i];
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arith%0d_in_ready: got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b0; sub = 1'b0;
      tick();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arith%0d_early_valid: got %b want 0", i, out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arith%0d_valid: got %b want 1", i, out_valid); end
      total++; if (s !== es[i]) begin bad++; $display("FAIL arith%0d_s: got %h want %h", i, s, es[i]); end
      total++; if (cout !== ec[i]) begin bad++; $display("FAIL arith%0d_cout: got %b want %b", i, cout, ec[i]); end
      total++; if (ovf !== eo[i]) begin bad++; $display("FAIL arith%0d_ovf: got %b want %b", i, ovf, eo[i]); end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    int sent;
    int got;
    int cyc;
    logic [15:0] e;
    sent = 0; got = 0; cyc = 0;
    exp_q.delete();
    out_ready = 1'b1;
    while (got < 6 && cyc < 200) begin
      in_valid = (sent < 6);
      a = 16'(sent); b = 16'(16'h0100 * sent); cin = 1'b0; sub = 1'b0;
      if (cyc == 2) out_ready = 1'b0;
      if (cyc == 12) out_ready = 1'b1;
      #1;
      if (cyc == 8 || cyc == 11) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_c%0d: got %b want 0", cyc, in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid_c%0d: got %b want 1", cyc, out_valid); end
        total++; if (s !== 16'h0000) begin bad++; $display("FAIL bp_hold_s_c%0d: got %h want 0000", cyc, s); end
        total++; if (sent !== 4) begin bad++; $display("FAIL bp_accepted_c%0d: got %0d want 4", cyc, sent); end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL bp_extra: got %h want none", s);
        end else begin
          e = exp_q.pop_front();
          total++; if (s !== e) begin bad++; $display("FAIL bp_s%0d: got %h want %h", got, s, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(16'(16'h0101 * sent));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (got !== 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got); end
  endtask

  task automatic test_back_to_back();
    int got;
    int cyc;
    logic [15:0] e;
    logic [15:0] ta;
    logic [15:0] tb;
    got = 0; cyc = 0;
    exp_q.delete();
    out_ready = 1'b1;
    while (cyc < 40 && (cyc < 14 || exp_q.size() != 0)) begin
      ta = 16'h1000 + 16'(cyc * 16'h0111);
      tb = 16'h00F0 + 16'(cyc);
      in_valid = (cyc < 14);
      a = ta; b = tb; cin = cyc[0]; sub = cyc[1];
      #1;
      if (cyc >= 4 && cyc < 14) begin
        total++; if (exp_q.size() !== 4) begin bad++; $display("FAIL b2b_occupancy_c%0d: got %0d want 4", cyc, exp_q.size()); end
        total++; if ({out_valid, in_ready} !== 2'b11) begin bad++; $display("FAIL b2b_flow_c%0d: got %b want 11", cyc, {out_valid, in_ready}); end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL b2b_extra: got %h want none", s);
        end else begin
          e = exp_q.pop_front();
          total++; if (s !== e) begin bad++; $display("FAIL b2b_s%0d: got %h want %h", got, s, e); end
        end
        got++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(sub ? (ta - tb) : (ta + tb + 16'(cin)));
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    total++; if (got !== 14) begin bad++; $display("FAIL b2b_count: got %0d want 14", got); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'h0100 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL rstmid_s: got %h want 0000", s); end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale%0d: got %b want 0", i, out_valid); end
    end
    in_valid = 1'b1; a = 16'h0005; b = 16'h0006; cin = 1'b0; sub = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_post_valid: got %b want 1", out_valid); end
    total++; if (s !== 16'h000B) begin bad++; $display("FAIL rstmid_post_s: got %h want 000b", s); end
    tick();
  endtask

  // WIDTH == CHUNK: one registered stage, result the cycle after handshake.
  task automatic test_single_stage();
    s1_out_ready = 1'b1;
    s1_in_valid = 1'b1; s1_a = 4'h9; s1_b = 4'h8; s1_cin = 1'b0; s1_sub = 1'b0;
    #1;
    total++; if (s1_in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", s1_in_ready); end
    tick();
    s1_in_valid = 1'b0;
    total++; if (s1_out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", s1_out_valid); end
    total++; if ({s1_s, s1_cout, s1_ovf} !== 6'b0001_1_1) begin bad++; $display("FAIL single_result: got %b want 000111", {s1_s, s1_cout, s1_ovf}); end
    tick();
    total++; if (s1_out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", s1_out_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    s1_in_valid = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_sub = 1'b0; s1_out_ready = 1'b1;
    tick();
    test_reset();
    test_arith();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    test_single_stage();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
